xsim_link_mux: RTL and testbench

//  Sequences and shares one XsimLink endpoint among NCHAN client channels.
//  - Brings the link up: issues en_start once, then waits for link_up.
//  - TX: round-robin arbiter at packet granularity. Each packet goes out as a header word then its payload.
//  - RX: parses headers and routes each payload word to the addressed client channel.
//  - Sits between the simulation transport (XsimLink) and the portal/client logic.

---
 rtl/xsim_link_mux.sv | 197 +++++++++++++++++++
 tb/tb_xsim_link_mux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xsim_link_mux.sv
// Shares one XsimLink endpoint among NCHAN clients: link bring-up sequencing,
// packet-granular round-robin TX with a header word, and header-routed RX.
module xsim_link_mux #(
  parameter int DATAWIDTH  = 32,
  parameter int NCHAN      = 4,
  parameter int LINKNUMBER = 0,
  parameter int LISTENING  = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       start_listening,
  output logic [31:0]                start_linknumber,
  output logic                       en_start,
  input  logic                       link_up,
  output logic                       en_tx_enq,
  output logic [DATAWIDTH-1:0]       tx_enq_v,
  input  logic                       rdy_tx_enq,
  output logic                       en_rx_deq,
  input  logic [DATAWIDTH-1:0]       rx_first,
  input  logic                       rdy_rx_deq,
  input  logic [NCHAN-1:0]           cl_tx_valid,
  input  logic [NCHAN*DATAWIDTH-1:0] cl_tx_data,
  input  logic [NCHAN*16-1:0]        cl_tx_len,
  output logic [NCHAN-1:0]           cl_tx_ready,
  output logic [NCHAN-1:0]           cl_rx_valid,
  output logic [DATAWIDTH-1:0]       cl_rx_data,
  input  logic [NCHAN-1:0]           cl_rx_ready,
  output logic                       running,
  output logic                       err_bad_chan
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {L_IDLE, L_START, L_WAIT, L_RUN} link_st_t;
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_st_t;
  typedef enum logic [1:0] {R_HDR, R_DATA, R_DROP} rx_st_t;

  link_st_t l_st, l_nxt;
  tx_st_t   t_st, t_nxt;
  rx_st_t   r_st, r_nxt;

  logic [CW-1:0] rr_ptr, rr_nxt, tx_g, tx_g_nxt, gnt_idx, cand;
  logic          gnt_ok;
  logic [15:0]   tx_len, tx_len_nxt, tx_cnt, tx_cnt_nxt;
  logic [7:0]    rx_ch, rx_ch_nxt;
  logic [15:0]   rx_cnt, rx_cnt_nxt;
  logic          err_nxt;

  // A zero-length request still carries one word, so it becomes length 1.
  function automatic logic [15:0] coerce_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

  function automatic logic [DATAWIDTH-1:0] mk_hdr(input logic [CW-1:0] ch, input logic [15:0] len);
    logic [DATAWIDTH-1:0] h;
    h        = '0;
    h[23:16] = 8'(ch);
    h[15:0]  = len;
    return h;
  endfunction

  assign start_listening  = LISTENING[0];
  assign start_linknumber = LINKNUMBER[31:0];
  assign cl_rx_data       = rx_first;
  assign en_start         = (l_st == L_START);
  assign running          = (l_st == L_RUN) && link_up;

  always_ff @(posedge CLK) begin
    if (RST) begin
      l_st         <= L_IDLE;
      t_st         <= T_IDLE;
      r_st         <= R_HDR;
      rr_ptr       <= '0;
      err_bad_chan <= 1'b0;
    end else begin
      l_st         <= l_nxt;
      t_st         <= t_nxt;
      r_st         <= r_nxt;
      rr_ptr       <= rr_nxt;
      err_bad_chan <= err_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    tx_g   <= tx_g_nxt;
    tx_len <= tx_len_nxt;
    tx_cnt <= tx_cnt_nxt;
    rx_ch  <= rx_ch_nxt;
    rx_cnt <= rx_cnt_nxt;
  end

  always_comb begin
    l_nxt = l_st;
    case (l_st)
      L_IDLE:  l_nxt = L_START;
      L_START: l_nxt = L_WAIT;
      L_WAIT:  if (link_up) l_nxt = L_RUN;
      default: l_nxt = L_RUN;
    endcase
  end

  always_comb begin
    t_nxt       = t_st;
    rr_nxt      = rr_ptr;
    tx_g_nxt    = tx_g;
    tx_len_nxt  = tx_len;
    tx_cnt_nxt  = tx_cnt;
    en_tx_enq   = 1'b0;
    tx_enq_v    = '0;
    cl_tx_ready = '0;
    gnt_ok      = 1'b0;
    gnt_idx     = '0;
    cand        = '0;
    // Search starts just after the last served channel.
    for (int i = 1; i <= NCHAN; i++) begin
      cand = CW'((int'(rr_ptr) + i) % NCHAN);
      if (!gnt_ok && cl_tx_valid[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
    case (t_st)
      T_IDLE: begin
        if (running && gnt_ok) begin
          tx_g_nxt   = gnt_idx;
          tx_len_nxt = coerce_len(cl_tx_len[int'(gnt_idx)*16 +: 16]);
          t_nxt      = T_HDR;
        end
      end
      T_HDR: begin
        tx_enq_v  = mk_hdr(tx_g, tx_len);
        en_tx_enq = rdy_tx_enq && running;
        if (en_tx_enq) begin
          tx_cnt_nxt = tx_len;
          t_nxt      = T_DATA;
        end
      end
      T_DATA: begin
        tx_enq_v          = cl_tx_data[int'(tx_g)*DATAWIDTH +: DATAWIDTH];
        cl_tx_ready[tx_g] = rdy_tx_enq && running;
        en_tx_enq         = cl_tx_valid[tx_g] && cl_tx_ready[tx_g];
        if (en_tx_enq) begin
          tx_cnt_nxt = tx_cnt - 16'd1;
          if (tx_cnt == 16'd1) begin
            t_nxt  = T_IDLE;
            rr_nxt = tx_g;
          end
        end
      end
      default: t_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    r_nxt       = r_st;
    rx_ch_nxt   = rx_ch;
    rx_cnt_nxt  = rx_cnt;
    en_rx_deq   = 1'b0;
    cl_rx_valid = '0;
    err_nxt     = 1'b0;
    case (r_st)
      R_HDR: begin
        en_rx_deq = rdy_rx_deq && running;
        if (en_rx_deq) begin
          rx_ch_nxt  = rx_first[23:16];
          rx_cnt_nxt = rx_first[15:0];
          if (rx_first[15:0] == 16'd0) begin
            r_nxt = R_HDR;
          end else if ({1'b0, rx_first[23:16]} >= 9'(NCHAN)) begin
            err_nxt = 1'b1;
            r_nxt   = R_DROP;
          end else begin
            r_nxt = R_DATA;
          end
        end
      end
      R_DATA: begin
        for (int i = 0; i < NCHAN; i++)
          cl_rx_valid[i] = (rx_ch == 8'(i)) && rdy_rx_deq && running;
        en_rx_deq = |(cl_rx_valid & cl_rx_ready);
        if (en_rx_deq) begin
          rx_cnt_nxt = rx_cnt - 16'd1;
          if (rx_cnt == 16'd1) r_nxt = R_HDR;
        end
      end
      R_DROP: begin
        en_rx_deq = rdy_rx_deq && running;
        if (en_rx_deq) begin
          rx_cnt_nxt = rx_cnt - 16'd1;
          if (rx_cnt == 16'd1) r_nxt = R_HDR;
        end
      end
      default: r_nxt = R_HDR;
    endcase
  end

endmodule

// File: tb/tb_xsim_link_mux.sv
// Directed bench for xsim_link_mux: client/link models feed queues, and
// scoreboards of expected TX link words and RX deliveries are checked per cycle.
module tb_xsim_link_mux;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic              CLK, RST;
  logic              start_listening;
  logic [31:0]       start_linknumber;
  logic              en_start, link_up;
  logic              en_tx_enq, rdy_tx_enq;
  logic [DW-1:0]     tx_enq_v;
  logic              en_rx_deq, rdy_rx_deq;
  logic [DW-1:0]     rx_first;
  logic [NCH-1:0]    cl_tx_valid, cl_tx_ready, cl_rx_valid, cl_rx_ready;
  logic [NCH*DW-1:0] cl_tx_data;
  logic [NCH*16-1:0] cl_tx_len;
  logic [DW-1:0]     cl_rx_data;
  logic              running, err_bad_chan;

  xsim_link_mux #(.DATAWIDTH(DW), .NCHAN(NCH), .LINKNUMBER(5), .LISTENING(1)) dut (
    .CLK(CLK), .RST(RST),
    .start_listening(start_listening), .start_linknumber(start_linknumber),
    .en_start(en_start), .link_up(link_up),
    .en_tx_enq(en_tx_enq), .tx_enq_v(tx_enq_v), .rdy_tx_enq(rdy_tx_enq),
    .en_rx_deq(en_rx_deq), .rx_first(rx_first), .rdy_rx_deq(rdy_rx_deq),
    .cl_tx_valid(cl_tx_valid), .cl_tx_data(cl_tx_data), .cl_tx_len(cl_tx_len),
    .cl_tx_ready(cl_tx_ready), .cl_rx_valid(cl_rx_valid), .cl_rx_data(cl_rx_data),
    .cl_rx_ready(cl_rx_ready), .running(running), .err_bad_chan(err_bad_chan)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]    ch;
    logic [DW-1:0] d;
  } rx_t;

  logic [DW-1:0] chq [NCH][$];
  logic [15:0]   txlen [NCH];
  logic [DW-1:0] rxq [$];
  logic [DW-1:0] tx_exp [$];
  rx_t           rx_exp [$];

  int n_assert = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_err = 0;
  int first_fire = -1, last_fire = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      cl_tx_valid[i]          = (chq[i].size() != 0);
      cl_tx_data[i*DW +: DW]  = (chq[i].size() != 0) ? chq[i][0] : '0;
      cl_tx_len[i*16 +: 16]   = txlen[i];
    end
    rdy_rx_deq = (rxq.size() != 0);
    rx_first   = (rxq.size() != 0) ? rxq[0] : '0;
  endtask

  task automatic tick();
    logic [NCH-1:0] txm;
    logic           rxd;
    rx_t            e;
    txm = '0;
    rxd = 1'b0;
    @(negedge CLK);
    cyc++;
    if (en_start) n_start++;
    if (err_bad_chan) n_err++;
    if (!RST) begin
      if (cl_tx_ready != '0) check("tx_ready_onehot", $countones(cl_tx_ready), 1);
      if (en_tx_enq) begin
        txm = cl_tx_valid & cl_tx_ready;
        check("tx_pending", tx_exp.size() != 0, 1);
        if (tx_exp.size() != 0) begin
          check("tx_word", tx_enq_v, tx_exp.pop_front());
          if (first_fire < 0) first_fire = cyc;
          last_fire = cyc;
        end
      end
      if (en_rx_deq) begin
        rxd = 1'b1;
        if (cl_rx_valid != '0) begin
          check("rx_pending", rx_exp.size() != 0, 1);
          check("rx_ready_ok", |(cl_rx_valid & cl_rx_ready), 1);
          if (rx_exp.size() != 0) begin
            e = rx_exp.pop_front();
            check("rx_chan", cl_rx_valid, 64'(1) << e.ch);
            check("rx_data", cl_rx_data, e.d);
          end
        end
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NCH; i++)
      if (txm[i]) void'(chq[i].pop_front());
    if (rxd) void'(rxq.pop_front());
    drive();
  endtask

  task automatic check_reset_outputs();
    check("rst_en_start", en_start, 0);
    check("rst_en_tx_enq", en_tx_enq, 0);
    check("rst_en_rx_deq", en_rx_deq, 0);
    check("rst_running", running, 0);
    check("rst_err_bad_chan", err_bad_chan, 0);
    check("rst_cl_tx_ready", cl_tx_ready, 0);
    check("rst_cl_rx_valid", cl_rx_valid, 0);
  endtask

  task automatic bring_up();
    int n0, n;
    n0 = n_start;
    n  = 0;
    while (n_start == n0 && n < 10) begin tick(); n++; end
    check("en_start_seen", n_start - n0, 1);
    repeat (4) tick();
    link_up = 1'b1;
    check("running_before_up", running, 0);
    tick();
    check("running_after_up", running, 1);
    repeat (3) tick();
    check("en_start_once", n_start - n0, 1);
  endtask

  task automatic wait_tx_drain(input string tag);
    int n = 0;
    while (tx_exp.size() != 0 && n < 40) begin tick(); n++; end
    check(tag, tx_exp.size(), 0);
  endtask

  task automatic wait_rx_drain(input string tag);
    int n = 0;
    while ((rx_exp.size() != 0 || rxq.size() != 0) && n < 40) begin tick(); n++; end
    check(tag, rx_exp.size() + rxq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    RST = 1'b1;
    link_up = 1'b0;
    rdy_tx_enq = 1'b1;
    cl_rx_ready = '1;
    for (int i = 0; i < NCH; i++) txlen[i] = 16'd0;
    drive();
    repeat (3) tick();
    check_reset_outputs();
    check("listening", start_listening, 1);
    check("linknumber", start_linknumber, 5);

    RST = 1'b0;
    bring_up();

    // Single packet, link always ready: four consecutive words.
    txlen[1] = 16'd3;
    chq[1] = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    tx_exp = '{32'h0001_0003, 32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    first_fire = -1;
    drive();
    wait_tx_drain("tx_single_drain");
    check("tx_consecutive", last_fire - first_fire, 3);

    // Contention after ch1 was served: ch2 wins, then ch0, whole packets each.
    txlen[0] = 16'd2;
    txlen[2] = 16'd2;
    chq[0] = '{32'hD000_0000, 32'hD000_0001};
    chq[2] = '{32'hE000_0000, 32'hE000_0001};
    tx_exp = '{32'h0002_0002, 32'hE000_0000, 32'hE000_0001,
               32'h0000_0002, 32'hD000_0000, 32'hD000_0001};
    drive();
    wait_tx_drain("tx_rr_drain");

    // Zero length request is sent as a one-word packet.
    txlen[3] = 16'd0;
    chq[3] = '{32'hF00D_F00D};
    tx_exp = '{32'h0003_0001, 32'hF00D_F00D};
    drive();
    wait_tx_drain("tx_len0_drain");

    // TX and RX traffic at the same time.
    txlen[1] = 16'd2;
    chq[1] = '{32'h1111_0001, 32'h1111_0002};
    tx_exp = '{32'h0001_0002, 32'h1111_0001, 32'h1111_0002};
    rxq = '{32'h0001_0001, 32'h2222_0001};
    rx_exp.push_back('{ch: 8'd1, d: 32'h2222_0001});
    drive();
    wait_tx_drain("txrx_tx_drain");
    wait_rx_drain("txrx_rx_drain");

    // RX backpressure on ch2 holds the link queue.
    cl_rx_ready = 4'b1011;
    rxq = '{32'h0002_0002, 32'h5800_0058, 32'h5900_0059};
    rx_exp.push_back('{ch: 8'd2, d: 32'h5800_0058});
    rx_exp.push_back('{ch: 8'd2, d: 32'h5900_0059});
    drive();
    tick();
    repeat (3) begin
      check("rx_hold_no_deq", en_rx_deq, 0);
      check("rx_hold_valid", cl_rx_valid, 4'b0100);
      check("rx_hold_data", cl_rx_data, 32'h5800_0058);
      tick();
    end
    cl_rx_ready = '1;
    wait_rx_drain("rx_bp_drain");

    // Zero-length header, then bad channel dropped, then a normal packet.
    e0 = n_err;
    rxq = '{32'h0000_0000, 32'h00FF_0002, 32'hBAD0_0001, 32'hBAD0_0002,
            32'h0001_0001, 32'h600D_0001};
    rx_exp.push_back('{ch: 8'd1, d: 32'h600D_0001});
    drive();
    wait_rx_drain("rx_drop_drain");
    tick();
    check("err_bad_chan_once", n_err - e0, 1);

    // Reset in the middle of a packet abandons it and restarts the link.
    txlen[0] = 16'd4;
    chq[0] = '{32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003};
    tx_exp = '{32'h0000_0004, 32'h7000_0000, 32'h7000_0001};
    drive();
    wait_tx_drain("tx_partial_drain");
    RST = 1'b1;
    link_up = 1'b0;
    chq[0].delete();
    drive();
    tick();
    check_reset_outputs();
    RST = 1'b0;
    bring_up();
    txlen[0] = 16'd1;
    chq[0] = '{32'h7E57_0001};
    tx_exp = '{32'h0000_0001, 32'h7E57_0001};
    drive();
    wait_tx_drain("tx_after_reset_drain");
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
